ports_gpio_ctrl: RTL and testbench

Parametrised, clocked successor of the combinational port function block. It holds the port SFRs locally: output data, direction, interrupt enable, edge select and interrupt flags. Inputs pass through a synchroniser and a per-bit debounce filter. Debounced edges raise maskable pin-change interrupts. The block sits between the SFR bus and the pad ring, one instance per port.

---
 rtl/ports_gpio_ctrl.sv | 107 ++++++++++
 tb/tb_ports_gpio_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ports_gpio_ctrl.sv
// Clocked GPIO port: local SFRs, input synchroniser, per-bit debounce filter
// and pin-change interrupt flags. One instance per port, between SFR bus and pads.
module ports_gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sfr_wr_i,
    input  logic [2:0]       sfr_addr_i,
    input  logic [WIDTH-1:0] sfr_wdata_i,
    output logic [WIDTH-1:0] sfr_rdata_o,
    input  logic [WIDTH-1:0] y_portX_i,
    output logic [WIDTH-1:0] en_portX_o,
    output logic [WIDTH-1:0] a_portX_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [2:0] ADDR_PX    = 3'd0;
    localparam logic [2:0] ADDR_PXEN  = 3'd1;
    localparam logic [2:0] ADDR_PXIE  = 3'd2;
    localparam logic [2:0] ADDR_PXIES = 3'd3;
    localparam logic [2:0] ADDR_PXIFG = 3'd4;
    localparam logic [2:0] ADDR_PXIN  = 3'd5;

    logic [WIDTH-1:0] px, pxen, pxie, pxies, pxifg;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync, stable, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] edge_set, ifg_clr, ifg_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets its default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable;
        cnt_d    = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
                cnt_d[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // A flag is raised only by a change of the debounced level, never by PXIES.
    assign edge_set = (stable_d & ~stable & ~pxies) | (~stable_d & stable & pxies);
    assign ifg_clr  = (sfr_wr_i && sfr_addr_i == ADDR_PXIFG) ? sfr_wdata_i : '0;
    assign ifg_d    = (pxifg & ~ifg_clr) | edge_set;

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values; the synchroniser is reset too, so a pin held high
    // through reset is reported as a fresh rising edge afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px     <= '0;
            pxen   <= '0;
            pxie   <= '0;
            pxies  <= '0;
            pxifg  <= '0;
            sync_q <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], y_portX_i};
            stable <= stable_d;
            cnt    <= cnt_d;
            pxifg  <= ifg_d;
            if (sfr_wr_i) begin
                case (sfr_addr_i)
                    ADDR_PX:    px    <= sfr_wdata_i;
                    ADDR_PXEN:  pxen  <= sfr_wdata_i;
                    ADDR_PXIE:  pxie  <= sfr_wdata_i;
                    ADDR_PXIES: pxies <= sfr_wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        sfr_rdata_o = '0;
        case (sfr_addr_i)
            ADDR_PX:    sfr_rdata_o = px;
            ADDR_PXEN:  sfr_rdata_o = pxen;
            ADDR_PXIE:  sfr_rdata_o = pxie;
            ADDR_PXIES: sfr_rdata_o = pxies;
            ADDR_PXIFG: sfr_rdata_o = pxifg;
            ADDR_PXIN:  sfr_rdata_o = stable;
            default:    sfr_rdata_o = '0;
        endcase
    end

    assign en_portX_o = ~pxen;
    assign a_portX_o  = px;
    assign irq_o      = |(pxifg & pxie);

endmodule

// File: tb/tb_ports_gpio_ctrl.sv
// Self-checking bench for ports_gpio_ctrl: directed test-plan cases with literal
// expectations plus randomized traffic compared every cycle against a port model.
module tb_ports_gpio_ctrl;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr;
    logic [2:0]   addr;
    logic [W-1:0] wdata, rdata, y, en, a;
    logic         irq;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    ports_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sfr_wr_i   (wr),
        .sfr_addr_i (addr),
        .sfr_wdata_i(wdata),
        .sfr_rdata_o(rdata),
        .y_portX_i  (y),
        .en_portX_o (en),
        .a_portX_o  (a),
        .irq_o      (irq)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Port model: registers as plain values, synchroniser as a sample queue,
    // debounce as a count of consecutive edges where the synced level disagrees.
    logic [W-1:0] m_px, m_en, m_ie, m_ies, m_ifg, m_stable;
    logic [W-1:0] m_q[$];
    int           m_run[W];
    logic [W-1:0] syncv, newst, setv;

    always @(posedge clk) begin
        if (rst) begin
            m_px = '0; m_en = '0; m_ie = '0; m_ies = '0; m_ifg = '0; m_stable = '0;
            m_q.delete();
            repeat (SYNC) m_q.push_back('0);
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            syncv = m_q[0];
            newst = m_stable;
            for (int i = 0; i < W; i++) begin
                if (syncv[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        newst[i] = syncv[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            setv = (newst & ~m_stable & ~m_ies) | (~newst & m_stable & m_ies);
            if (wr && addr == 3'd4) m_ifg = (m_ifg & ~wdata) | setv;
            else                    m_ifg = m_ifg | setv;
            if (wr) begin
                case (addr)
                    3'd0:    m_px  = wdata;
                    3'd1:    m_en  = wdata;
                    3'd2:    m_ie  = wdata;
                    3'd3:    m_ies = wdata;
                    default: ;
                endcase
            end
            m_stable = newst;
            void'(m_q.pop_front());
            m_q.push_back(y);
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [2:0] ad);
        case (ad)
            3'd0:    return m_px;
            3'd1:    return m_en;
            3'd2:    return m_ie;
            3'd3:    return m_ies;
            3'd4:    return m_ifg;
            3'd5:    return m_stable;
            default: return '0;
        endcase
    endfunction

    logic [W-1:0] exp_en;
    always @(negedge clk) begin
        if (cmp_on) begin
            exp_en = ~m_en;
            check("model_en", en, exp_en);
            check("model_a", a, m_px);
            check("model_irq", {7'd0, irq}, {7'd0, |(m_ifg & m_ie)});
            check("model_rdata", rdata, exp_rd(addr));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_sfr(input logic [2:0] ad, input logic [W-1:0] d);
        wr = 1'b1; addr = ad; wdata = d;
        step();
        wr = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] ad, input logic [W-1:0] exp);
        addr = ad;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr = 1'b0; addr = '0; wdata = '0; y = '0;
        step(); step();
        cmp_on = 1'b1;
        check("reset_en", en, 8'hFF);
        check("reset_a", a, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr = 3'(k);
            step();
            check("reset_read", rdata, 8'h00);
        end

        // Direction and data
        wr_sfr(3'd1, 8'hF0);
        check("dir_en", en, 8'h0F);
        wr_sfr(3'd0, 8'hA5);
        check("data_a", a, 8'hA5);
        rd_check("read_pxen", 3'd1, 8'hF0);
        rd_check("read_px", 3'd0, 8'hA5);

        // Three-cycle glitch must be filtered out
        y[0] = 1'b1;
        repeat (3) step();
        y[0] = 1'b0;
        repeat (10) step();
        rd_check("glitch_pxin", 3'd5, 8'h00);
        rd_check("glitch_ifg", 3'd4, 8'h00);

        // Held rise: PXIN and flag exactly at edge LAT, irq with PXIE[0]
        wr_sfr(3'd2, 8'h01);
        addr = 3'd5;
        y[0] = 1'b1;
        repeat (LAT - 1) step();
        check("rise_pxin_early", rdata, 8'h00);
        check("rise_irq_early", {7'd0, irq}, 8'h00);
        step();
        check("rise_pxin", rdata, 8'h01);
        check("rise_irq", {7'd0, irq}, 8'h01);
        rd_check("rise_ifg", 3'd4, 8'h01);
        wr_sfr(3'd4, 8'h01);
        check("clear_irq", {7'd0, irq}, 8'h00);
        check("clear_ifg", rdata, 8'h00);

        // Falling edge on pin 3 while masked
        y[3] = 1'b1;
        repeat (LAT + 2) step();
        rd_check("pin3_rise_flag", 3'd4, 8'h08);
        check("pin3_masked_irq", {7'd0, irq}, 8'h00);
        wr_sfr(3'd4, 8'h08);
        wr_sfr(3'd3, 8'h08);
        rd_check("ies_change_no_flag", 3'd4, 8'h00);
        y[3] = 1'b0;
        repeat (LAT + 2) step();
        rd_check("fall_flag", 3'd4, 8'h08);
        check("fall_masked_irq", {7'd0, irq}, 8'h00);
        wr_sfr(3'd2, 8'h09);
        check("fall_unmasked_irq", {7'd0, irq}, 8'h01);
        wr_sfr(3'd4, 8'h08);
        check("fall_cleared_irq", {7'd0, irq}, 8'h00);

        // Set and clear on the same edge: set wins
        y[0] = 1'b0;
        repeat (LAT + 2) step();
        rd_check("pin0_fall_no_flag", 3'd4, 8'h00);
        y[0] = 1'b1;
        repeat (LAT - 1) step();
        wr_sfr(3'd4, 8'h01);
        check("set_wins_ifg", rdata, 8'h01);
        check("set_wins_irq", {7'd0, irq}, 8'h01);
        wr_sfr(3'd4, 8'h01);
        check("set_wins_cleared", rdata, 8'h00);

        // Randomized traffic, checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) y[b] = ~y[b];
            end
            step();
        end
        wr = 1'b0;

        // Pins held high through reset report a rising edge LAT edges later
        y = 8'h81; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        addr = 3'd5;
        repeat (LAT - 1) step();
        check("rst_high_pxin_early", rdata, 8'h00);
        step();
        check("rst_high_pxin", rdata, 8'h81);
        check("rst_high_irq", {7'd0, irq}, 8'h00);
        rd_check("rst_high_ifg", 3'd4, 8'h81);

        step();
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
